// File: rtl/rtsnoc_int_tx_arb.sv
// rtsnoc_int_tx_arb
// Reports level changes on N_INT interrupt lines to one fixed RTSNoC node.
// All sources share a single router port. A round-robin arbiter picks one
// pending source at a time and sends an UP, DOWN or PULSE packet for it.
// The write handshake waits for the router to accept the packet.
//
// Ports:
//   clk_i       clock
//   rst_i       synchronous reset, active-high
//   int_i       interrupt levels, asynchronous; bit i belongs to source i
//   noc_din_o   packet to router: {X_orig, Y_orig, local_orig, X_dst, Y_dst,
//               local_dst, data}
//   noc_wr_o    write request, held high until the router accepts
//   noc_rd_o    read strobe; drains received flits
//   noc_dout_i  received packet; discarded
//   noc_wait_i  router backpressure
//   noc_nd_i    router has new data
module rtsnoc_int_tx_arb #(
  parameter int NOC_DATA_WIDTH    = 32,
  parameter int NOC_LOCAL_ADR     = 0,
  parameter int NOC_X             = 0,
  parameter int NOC_Y             = 0,
  parameter int NOC_LOCAL_ADR_TGT = 0,
  parameter int NOC_X_TGT         = 0,
  parameter int NOC_Y_TGT         = 0,
  parameter int SOC_SIZE_X        = 1,
  parameter int SOC_SIZE_Y        = 1,
  parameter int N_INT             = 4
) (
  input  logic                                                         clk_i,
  input  logic                                                         rst_i,
  input  logic [N_INT-1:0]                                             int_i,
  output logic [NOC_DATA_WIDTH+2*SOC_SIZE_X+2*SOC_SIZE_Y+6-1:0]        noc_din_o,
  output logic                                                         noc_wr_o,
  output logic                                                         noc_rd_o,
  input  logic [NOC_DATA_WIDTH+2*SOC_SIZE_X+2*SOC_SIZE_Y+6-1:0]        noc_dout_i,
  input  logic                                                         noc_wait_i,
  input  logic                                                         noc_nd_i
);

  localparam int IW = (N_INT > 1) ? $clog2(N_INT) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [1:0] TYPE_UP    = 2'd1;
  localparam logic [1:0] TYPE_DOWN  = 2'd2;
  localparam logic [1:0] TYPE_PULSE = 2'd3;

  // Fixed header fields.
  localparam logic [SOC_SIZE_X-1:0] X_ORIG = SOC_SIZE_X'(NOC_X);
  localparam logic [SOC_SIZE_Y-1:0] Y_ORIG = SOC_SIZE_Y'(NOC_Y);
  localparam logic [2:0]            L_ORIG = 3'(NOC_LOCAL_ADR);
  localparam logic [SOC_SIZE_X-1:0] X_DST  = SOC_SIZE_X'(NOC_X_TGT);
  localparam logic [SOC_SIZE_Y-1:0] Y_DST  = SOC_SIZE_Y'(NOC_Y_TGT);
  localparam logic [2:0]            L_DST  = 3'(NOC_LOCAL_ADR_TGT);

  logic [N_INT-1:0]          s1_q, s2_q;
  logic [N_INT-1:0]          r_q, r_d;
  logic [N_INT-1:0]          rise_q, rise_d, fall_q, fall_d;
  logic [N_INT-1:0]          rise_set, fall_set, pend, gnt_clr;
  logic [IW-1:0]             ptr_q, gnt_idx, arb_idx;
  logic                      gnt_found, grant;
  logic [1:0]                gnt_type;
  logic [NOC_DATA_WIDTH-1:0] tx_data_q, payload;
  logic [0:0]                state_q;
  logic                      wr_q, rd_q;

  // Per-source edge tracking. The set terms are folded into pend so that
  // an edge can be granted in the same cycle it is first seen on s2.
  for (genvar gi = 0; gi < N_INT; gi++) begin : g_src
    assign rise_set[gi] = s2_q[gi] & ~r_q[gi];
    assign fall_set[gi] = ~s2_q[gi] & r_q[gi];
    assign pend[gi]     = rise_q[gi] | fall_q[gi] | rise_set[gi] | fall_set[gi];
    assign gnt_clr[gi]  = grant && (gnt_idx == IW'(gi));
    // Clear on grant has priority over a new set in the same cycle.
    assign rise_d[gi]   = ~gnt_clr[gi] & (rise_q[gi] | rise_set[gi]);
    assign fall_d[gi]   = ~gnt_clr[gi] & (fall_q[gi] | fall_set[gi]);
    // Only an UP grant raises the reported level; DOWN lowers it;
    // PULSE leaves it low.
    assign r_d[gi]      = gnt_clr[gi] ? (~r_q[gi] & s2_q[gi] & s1_q[gi]) : r_q[gi];
  end

  // Round-robin search starting one past the last granted index.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    arb_idx   = ptr_q;
    for (int k = 0; k < N_INT; k++) begin
      if (arb_idx == IW'(N_INT - 1)) begin
        arb_idx = '0;
      end else begin
        arb_idx = arb_idx + IW'(1);
      end
      if (!gnt_found && pend[arb_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = arb_idx;
      end
    end
  end

  assign grant = (state_q == ST_IDLE) && gnt_found;

  // A low source is reported UP only if the level survived both sync
  // stages; anything that already fell back is a PULSE.
  always_comb begin
    if (r_q[gnt_idx]) begin
      gnt_type = TYPE_DOWN;
    end else if (s2_q[gnt_idx] & s1_q[gnt_idx]) begin
      gnt_type = TYPE_UP;
    end else begin
      gnt_type = TYPE_PULSE;
    end
    payload       = '0;
    payload[1:0]  = gnt_type;
    payload[15:8] = 8'(gnt_idx);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q      <= '0;
      s2_q      <= '0;
      r_q       <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      ptr_q     <= IW'(N_INT - 1);
      tx_data_q <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      state_q   <= ST_IDLE;
    end else begin
      s1_q   <= int_i;
      s2_q   <= s1_q;
      r_q    <= r_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      rd_q   <= noc_nd_i & ~rd_q;
      if (state_q == ST_IDLE) begin
        if (grant) begin
          tx_data_q <= payload;
          wr_q      <= 1'b1;
          ptr_q     <= gnt_idx;
          state_q   <= ST_SEND;
        end
      end else begin
        if (!noc_wait_i) begin
          wr_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
      end
    end
  end

  assign noc_din_o = {X_ORIG, Y_ORIG, L_ORIG, X_DST, Y_DST, L_DST, tx_data_q};
  assign noc_wr_o  = wr_q;
  assign noc_rd_o  = rd_q;

  // Received flits are drained and dropped.
  logic unused_dout;
  assign unused_dout = ^noc_dout_i;

endmodule
